program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_assembler.sv | 32 +++
 rtl/program_loader.sv | 102 ++++++++++
 tb/tb_program_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loaderState_t;

  typedef logic [15:0] wordCount_t;

  // The image header is a big-endian 16-bit word count.
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/byte_assembler.sv
// Collects four stream bytes big-endian into one 32-bit word.
module byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        shiftEn,
  input  logic        clearReady,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic [1:0]  byteCount,
  output logic        wordReady
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word      <= '0;
      byteCount <= '0;
      wordReady <= 1'b0;
    end else begin
      if (shiftEn) begin
        word      <= {word[23:0], byteIn};
        byteCount <= byteCount + 2'd1;
      end
      // Clear takes priority; it is only driven while the word is being written.
      if (clearReady) begin
        wordReady <= 1'b0;
      end else if (shiftEn && byteCount == 2'd3) begin
        wordReady <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed image into instruction memory, holding the CPU in reset until done.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   HDR_HI | taking word-count high byte
//   HDR_LO | taking word-count low byte, validating it
//   DATA   | assembling the next 32-bit word
//   WRITE  | one-cycle memory write strobe
//   DONE   | image loaded, CPU released
//   ERROR  | header rejected, CPU held
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        hold_cpu,
  output logic        done,
  output logic        error
);

  loaderState_t state, nextState;
  wordCount_t   wordCount, wordIndex, headerWord;
  logic [31:0]  heldAddress, heldData, writeAddress, asmWord;
  logic [1:0]   byteCount;
  logic         wordReady, accept, lastWord, tooLarge;

  assign byte_ready   = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign accept       = byte_valid && byte_ready;
  assign headerWord   = {wordCount[15:8], byte_data};
  assign tooLarge     = {16'd0, headerWord} > 32'(MAX_WORDS);
  assign lastWord     = (wordIndex + 16'd1) == wordCount;
  assign writeAddress = BASE_ADDRESS + {14'd0, wordIndex, 2'b00};

  byte_assembler uAssembler (
    .clock      (clock),
    .reset      (reset),
    .shiftEn    (accept && state == DATA),
    .clearReady (state == WRITE),
    .byteIn     (byte_data),
    .word       (asmWord),
    .byteCount  (byteCount),
    .wordReady  (wordReady)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:   if (start) nextState = HDR_HI;
      HDR_HI: if (accept) nextState = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (headerWord == '0)  nextState = DONE;
          else if (tooLarge)     nextState = ERROR;
          else                   nextState = DATA;
        end
      end
      DATA:   if (accept && byteCount == 2'd3) nextState = WRITE;
      WRITE:  nextState = lastWord ? DONE : DATA;
      DONE,
      ERROR:  if (start) nextState = HDR_HI;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wordCount   <= '0;
      wordIndex   <= '0;
      heldAddress <= BASE_ADDRESS;
      heldData    <= '0;
    end else begin
      state <= nextState;
      if (state == HDR_HI && accept) wordCount[15:8] <= byte_data;
      if (state == HDR_LO && accept) wordCount[7:0]  <= byte_data;
      if (state == WRITE) begin
        wordIndex   <= wordIndex + 16'd1;
        heldAddress <= writeAddress;
        heldData    <= asmWord;
      end
      if ((state == DONE || state == ERROR) && start) wordIndex <= '0;
    end
  end

  // Write port shows the live word during WRITE and the last written one otherwise.
  assign mem_write      = (state == WRITE) && wordReady;
  assign mem_address    = (state == WRITE) ? writeAddress : heldAddress;
  assign mem_write_data = (state == WRITE) ? asmWord : heldData;
  assign hold_cpu       = (state != DONE);
  assign done           = (state == DONE);
  assign error          = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized checks of program_loader against a byte-image reference model.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_write, hold_cpu, done, error;
  logic [31:0] mem_address, mem_write_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] seenWrites[$];
  int badReady = 0;

  program_loader #(.BASE_ADDRESS(BASE), .MAX_WORDS(MAXW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .byte_ready     (byte_ready),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .hold_cpu       (hold_cpu),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_write) begin
      seenWrites.push_back({mem_address, mem_write_data});
      if (byte_ready) badReady++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit jitter);
    int n = 0;
    bit got = 1'b0;
    if (jitter) begin
      while ($urandom_range(0, 2) == 0 && n < 8) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clock);
        n++;
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!got && n < 200) begin
      if (byte_ready) got = 1'b1;
      @(negedge clock);
      n++;
    end
    byte_valid = 1'b0;
    check("byteAccept", 64'(got), 64'd1);
  endtask

  task automatic sendImage(input logic [7:0] img[$], input bit jitter);
    foreach (img[i]) sendByte(img[i], jitter);
  endtask

  task automatic waitEnd(input string tag);
    int n = 0;
    while (!(done || error) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check(tag, 64'(done || error), 64'd1);
  endtask

  // Reference: header gives the word count, then words are big-endian at consecutive addresses.
  task automatic checkWrites(input string tag, input logic [7:0] img[$]);
    int words;
    int off;
    words = int'({img[0], img[1]});
    off   = loader_pkg::HDR_BYTES;
    check({tag, ".count"}, 64'(seenWrites.size()), 64'(words));
    for (int i = 0; i < words && i < seenWrites.size(); i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = BASE + 32'(4 * i);
      d = {img[off + 4*i], img[off + 4*i + 1], img[off + 4*i + 2], img[off + 4*i + 3]};
      check($sformatf("%s.w%0d", tag, i), seenWrites[i], {a, d});
    end
  endtask

  task automatic randomImage(input int words, output logic [7:0] img[$]);
    img.delete();
    img.push_back(8'(words >> 8));
    img.push_back(8'(words));
    for (int i = 0; i < 4 * words; i++) img.push_back(8'($urandom));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".hold"},  64'(hold_cpu), 64'd1);
    check({tag, ".ready"}, 64'(byte_ready), 64'd0);
    check({tag, ".wr"},    64'(mem_write), 64'd0);
    check({tag, ".addr"},  64'(mem_address), 64'(BASE));
    check({tag, ".data"},  64'(mem_write_data), 64'd0);
    check({tag, ".done"},  64'(done), 64'd0);
    check({tag, ".err"},   64'(error), 64'd0);
  endtask

  initial begin
    logic [7:0] img[$];

    // Reset state
    tick(2);
    checkResetOutputs("rst");
    reset = 1'b1;
    tick(2);
    check("idle.ready", 64'(byte_ready), 64'd0);
    check("idle.hold",  64'(hold_cpu), 64'd1);

    // Basic two-word image with single-cycle write latency
    seenWrites.delete();
    img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    pulseStart();
    foreach (img[i]) begin
      sendByte(img[i], 1'b0);
      if (i == 5) check("A.latency", 64'(mem_write), 64'd1);
    end
    waitEnd("A.end");
    checkWrites("A", img);
    check("A.done",  64'(done), 64'd1);
    check("A.hold",  64'(hold_cpu), 64'd0);
    check("A.heldAddr", 64'(mem_address), 64'h4);
    check("A.heldData", 64'(mem_write_data), 64'h0123_4567);
    tick(3);
    check("A.sticky", 64'(done), 64'd1);

    // Empty image: DONE right after the second header byte
    seenWrites.delete();
    pulseStart();
    check("B.doneClr", 64'(done), 64'd0);
    check("B.holdSet", 64'(hold_cpu), 64'd1);
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    check("B.done", 64'(done), 64'd1);
    check("B.hold", 64'(hold_cpu), 64'd0);
    check("B.noWrite", 64'(seenWrites.size()), 64'd0);

    // Oversized header
    seenWrites.delete();
    pulseStart();
    sendByte(8'h04, 1'b0);
    sendByte(8'h01, 1'b0);
    tick(3);
    check("C.err",   64'(error), 64'd1);
    check("C.hold",  64'(hold_cpu), 64'd1);
    check("C.ready", 64'(byte_ready), 64'd0);
    check("C.done",  64'(done), 64'd0);
    check("C.noWrite", 64'(seenWrites.size()), 64'd0);

    // Three random words with random valid gaps
    seenWrites.delete();
    badReady = 0;
    pulseStart();
    check("D.errClr", 64'(error), 64'd0);
    randomImage(3, img);
    sendImage(img, 1'b1);
    waitEnd("D.end");
    checkWrites("D", img);
    check("D.readyInWrite", 64'(badReady), 64'd0);
    check("D.done", 64'(done), 64'd1);

    // Reset after the sixth byte, then reload a single word
    pulseStart();
    randomImage(2, img);
    for (int i = 0; i < 6; i++) sendByte(img[i], 1'b0);
    reset = 1'b0;
    tick(1);
    checkResetOutputs("E.rst");
    reset = 1'b1;
    seenWrites.delete();
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    tick(4);
    byte_valid = 1'b0;
    check("E.idleReady", 64'(byte_ready), 64'd0);
    check("E.idleNoWrite", 64'(seenWrites.size()), 64'd0);
    randomImage(1, img);
    pulseStart();
    sendImage(img, 1'b0);
    waitEnd("E.end");
    checkWrites("E", img);

    // Start pulse mid-DATA is ignored
    seenWrites.delete();
    randomImage(2, img);
    pulseStart();
    for (int i = 0; i < 4; i++) sendByte(img[i], 1'b0);
    pulseStart();
    for (int i = 4; i < img.size(); i++) sendByte(img[i], 1'b0);
    waitEnd("F.end");
    checkWrites("F", img);

    // Restart from DONE starts a fresh load at the base address
    seenWrites.delete();
    pulseStart();
    check("G.doneClr", 64'(done), 64'd0);
    check("G.holdSet", 64'(hold_cpu), 64'd1);
    randomImage(1, img);
    sendImage(img, 1'b1);
    waitEnd("G.end");
    checkWrites("G", img);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
